nibble_serial_subtractor: RTL and testbench

Multi-cycle unsigned/two's-complement subtractor computing diff = a − b one 4-bit nibble per clock, with a ripple borrow carried between cycles. Each nibble uses a 4-bit parallel-prefix adder slice on a + ~b + carry. Sits beside the prefix adders in the ALU datapath as the area-cheap subtract/compare path. Uses valid/ready handshakes on both input and output.

---
 rtl/sub_pkg.sv | 18 +
 rtl/prefix_add4.sv | 37 +++
 rtl/nibble_serial_subtractor.sv | 134 +++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
  } flags_t;

endpackage

// File: rtl/prefix_add4.sv
// Combinational 4-bit generate/propagate prefix adder slice with carry-in.
module prefix_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g10, p10, g32, p32, g20, p20, g30, p30;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Two-level prefix tree: pairs first, then spans reaching bit 0.
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g10 | (p10 & cin);
  assign c[3] = g20 | (p20 & cin);
  assign c[4] = g30 | (p30 & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b, one nibble per clock via a shared prefix slice.
// Optional status flags {ovf, neg, zero} are built when SUB_FLAGS_EN is defined.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int N  = WIDTH / NIBBLE_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t           state_r, state_next;
  logic [WIDTH-1:0] a_r, nb_r, diff_r, diff_next;
  logic             carry_r, borrow_r;
  logic [KW-1:0]    k_r;
  logic [3:0]       a_nib, b_nib, sum_nib;
  logic             c4, last_nib;

  assign a_nib    = a_r[k_r*NIBBLE_W +: NIBBLE_W];
  assign b_nib    = nb_r[k_r*NIBBLE_W +: NIBBLE_W];
  assign last_nib = (k_r == KW'(N - 1));

  prefix_add4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_r),
    .sum  (sum_nib),
    .cout (c4)
  );

  // Result word with the current nibble merged in; also feeds the flag logic.
  always_comb begin
    diff_next = diff_r;
    diff_next[k_r*NIBBLE_W +: NIBBLE_W] = sum_nib;
  end

`ifdef SUB_FLAGS_EN
  logic   a_msb_r, b_msb_r;
  flags_t flags_r, flags_next;

  // Status flags of the final result, evaluated on the last nibble.
  always_comb begin
    flags_next.zero = (diff_next == {WIDTH{1'b0}});
    flags_next.neg  = diff_next[WIDTH-1];
    flags_next.ovf  = (a_msb_r != b_msb_r) && (diff_next[WIDTH-1] != a_msb_r);
  end

  assign flags = flags_r;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:    if (in_valid)  state_next = BUSY; else state_next = IDLE;
      BUSY:    if (last_nib)  state_next = DONE; else state_next = BUSY;
      DONE:    if (out_ready) state_next = IDLE; else state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-nibble ripple and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      nb_r     <= {WIDTH{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      k_r      <= {KW{1'b0}};
`ifdef SUB_FLAGS_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      flags_r  <= 3'b000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            nb_r    <= ~b;
            carry_r <= 1'b1;
            k_r     <= {KW{1'b0}};
`ifdef SUB_FLAGS_EN
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
`endif
          end
        end
        BUSY: begin
          diff_r  <= diff_next;
          carry_r <= c4;
          k_r     <= k_r + KW'(1);
          // Carry out of a + ~b + 1 is the inverted unsigned borrow.
          if (last_nib) begin
            borrow_r <= ~c4;
`ifdef SUB_FLAGS_EN
            flags_r  <= flags_next;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = (state_r == DONE);
  assign diff       = diff_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor at WIDTH = 16.
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = 16'h0000;
  logic [W-1:0] b = 16'h0000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SUB_FLAGS_EN
  logic [2:0]   flags;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_FLAGS_EN
    ,
    .flags      (flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation and wait for out_valid; lat = cycles after acceptance.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output bit seen);
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (lat <= 20) begin
      step();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff got=%h exp=0000", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
`ifdef SUB_FLAGS_EN
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", flags); end
`endif
  endtask

  task automatic test_basic();
    int lat; bit seen;
    start_op(16'h1234, 16'h0234, lat, seen);
    checks++; if (!seen) begin errors++; $display("FAIL basic_timeout got=no out_valid exp=out_valid"); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL basic_diff got=%h exp=1000", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL basic_borrow got=%b exp=0", borrow_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got=%b exp=0", in_ready); end
    finish_op();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{16'h0000, 16'h8000, 16'hABCD};
    logic [W-1:0] vb [3] = '{16'h0001, 16'h0001, 16'hABCD};
    logic [W-1:0] vd [3] = '{16'hFFFF, 16'h7FFF, 16'h0000};
    logic         vbo[3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0]   vf [3] = '{3'b010, 3'b100, 3'b001};
    int lat; bit seen;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], lat, seen);
      checks++; if (!seen) begin errors++; $display("FAIL vec%0d_timeout got=no out_valid exp=out_valid", i); end
      checks++; if (diff !== vd[i]) begin errors++; $display("FAIL vec%0d_diff got=%h exp=%h", i, diff, vd[i]); end
      checks++; if (borrow_out !== vbo[i]) begin errors++; $display("FAIL vec%0d_borrow got=%b exp=%b", i, borrow_out, vbo[i]); end
`ifdef SUB_FLAGS_EN
      checks++; if (flags !== vf[i]) begin errors++; $display("FAIL vec%0d_flags got=%b exp=%b", i, flags, vf[i]); end
`else
      if (vf[i] === 3'bxxx) $display("unreachable");
`endif
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit seen;
    start_op(16'h5A5A, 16'h1111, lat, seen);
    checks++; if (!seen) begin errors++; $display("FAIL bp_timeout got=no out_valid exp=out_valid"); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 16'hFFFF;
      b = 16'h0000;
      step();
      checks++; if (diff !== 16'h4949) begin errors++; $display("FAIL bp_diff_%0d got=%h exp=4949", i, diff); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hs_%0d got=in_ready %b out_valid %b exp=0 1", i, in_ready, out_valid); end
    end
    in_valid = 1'b0;
    finish_op();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got=in_ready %b out_valid %b exp=1 0", in_ready, out_valid); end
    step();
    step();
    checks++; if (in_ready !== 1'b1 || diff !== 16'h4949) begin
      errors++; $display("FAIL bp_idle_hold got=in_ready %b diff %h exp=1 4949", in_ready, diff); end
  endtask

  task automatic test_reset_midop();
    int lat; bit seen; bit ov_seen;
    a = 16'h00F0;
    b = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1 || diff !== 16'h0000) begin
      errors++; $display("FAIL midrst_clear got=in_ready %b diff %h exp=1 0000", in_ready, diff); end
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) ov_seen = 1'b1;
    end
    checks++; if (ov_seen || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_no_result got=out_valid_seen %b in_ready %b exp=0 1", ov_seen, in_ready); end
    start_op(16'h0005, 16'h0003, lat, seen);
    checks++; if (!seen || diff !== 16'h0002) begin
      errors++; $display("FAIL midrst_next_op got=seen %b diff %h exp=1 0002", seen, diff); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int first_cyc = -1;
    int second_cyc = -1;
    logic [W-1:0] d1 = 16'h0000;
    logic [W-1:0] d2 = 16'h0000;
    a = 16'h00FF;
    b = 16'h0100;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    a = 16'h7FFF;
    b = 16'hFFFF;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (out_valid && first_cyc < 0) begin
        first_cyc = c; d1 = diff;
      end else if (out_valid && second_cyc < 0) begin
        second_cyc = c; d2 = diff; in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (first_cyc !== 4 || d1 !== 16'hFFFF) begin
      errors++; $display("FAIL b2b_first got=cyc %0d diff %h exp=4 ffff", first_cyc, d1); end
    checks++; if (second_cyc !== 10 || d2 !== 16'h8000 || borrow_out !== 1'b1) begin
      errors++; $display("FAIL b2b_second got=cyc %0d diff %h borrow %b exp=10 8000 1", second_cyc, d2, borrow_out); end
  endtask

  initial begin
    #3;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
